// File: rtl/fb_pkg.sv
// Shared playfield frame-buffer constants used by the write scheduler, the VGA side and the game logic.
package fb_pkg;

  localparam int FB_W    = 10;
  localparam int FB_H    = 20;
  localparam int COLOR_W = 3;
  localparam int X_W     = 4;
  localparam int Y_W     = 5;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 3'b000;
  localparam logic [X_W-1:0]     X_LAST      = X_W'(FB_W - 1);
  localparam logic [Y_W-1:0]     Y_LAST      = Y_W'(FB_H - 1);

  function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(FB_W)) && (y < Y_W'(FB_H));
  endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Row-major x/y sweep counter for the frame-buffer clear; advances only while enabled (vblank).
module fb_clear_seq
  import fb_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load_i,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  // y saturates at the last row; a new clear reloads both counters anyway
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en_i) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        if (y_q != Y_LAST) y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/fb_write_sched.sv
// Frame-buffer write-port scheduler: round-robin arbitration of two requesters plus a full-buffer
// clear, with every write confined to the vertical-blank window.
module fb_write_sched
  import fb_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               vblank,
  input  logic [1:0]         req,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     x1,
  input  logic [Y_W-1:0]     y0,
  input  logic [Y_W-1:0]     y1,
  input  logic [COLOR_W-1:0] d0,
  input  logic [COLOR_W-1:0] d1,
  output logic [1:0]         gnt,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               fb_we,
  output logic [X_W-1:0]     fb_x,
  output logic [Y_W-1:0]     fb_y,
  output logic [COLOR_W-1:0] fb_data,
  output logic               range_err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q;
  logic               last_q;
  logic               fb_we_q;
  logic [X_W-1:0]     fb_x_q;
  logic [Y_W-1:0]     fb_y_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic               busy_q;
  logic               done_q;
  logic               rerr_q;

  logic [X_W-1:0]     clr_x;
  logic [Y_W-1:0]     clr_y;
  logic               clr_last;
  logic [X_W-1:0]     sel_x_d;
  logic [Y_W-1:0]     sel_y_d;
  logic [COLOR_W-1:0] sel_d_d;

  fb_clear_seq u_clear_seq (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == IDLE && clear_start),
    .en_i   (state_q == CLEAR && vblank),
    .x_o    (clr_x),
    .y_o    (clr_y),
    .last_o (clr_last)
  );

  // On contention the requester not granted last wins; last_q resets to 1 so req 0 wins first
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && !clear_start && vblank) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel_x_d = gnt[1] ? x1 : x0;
  assign sel_y_d = gnt[1] ? y1 : y0;
  assign sel_d_d = gnt[1] ? d1 : d0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      fb_we_q   <= 1'b0;
      fb_x_q    <= '0;
      fb_y_q    <= '0;
      fb_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      fb_we_q <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
            // Out-of-range requests are still consumed, just never written
            if (in_range(sel_x_d, sel_y_d)) begin
              fb_we_q   <= 1'b1;
              fb_x_q    <= sel_x_d;
              fb_y_q    <= sel_y_d;
              fb_data_q <= sel_d_d;
            end else begin
              rerr_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (vblank) begin
            fb_we_q   <= 1'b1;
            fb_x_q    <= clr_x;
            fb_y_q    <= clr_y;
            fb_data_q <= COLOR_BLACK;
            if (clr_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_data    = fb_data_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed self-checking bench for fb_write_sched: arbitration, vblank gating, range errors, clear and reset.
module tb_fb_write_sched;
  import fb_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               vblank = 1'b0;
  logic [1:0]         req = 2'b00;
  logic [X_W-1:0]     x0 = '0, x1 = '0;
  logic [Y_W-1:0]     y0 = '0, y1 = '0;
  logic [COLOR_W-1:0] d0 = '0, d1 = '0;
  logic [1:0]         gnt;
  logic               clear_start = 1'b0;
  logic               clear_busy, clear_done, fb_we, range_err;
  logic [X_W-1:0]     fb_x;
  logic [Y_W-1:0]     fb_y;
  logic [COLOR_W-1:0] fb_data;

  int total = 0;
  int bad   = 0;

  fb_write_sched dut (
    .clock       (clock),
    .reset       (reset),
    .vblank      (vblank),
    .req         (req),
    .x0          (x0),
    .x1          (x1),
    .y0          (y0),
    .y1          (y1),
    .d0          (d0),
    .d1          (d1),
    .gnt         (gnt),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .fb_we       (fb_we),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_data     (fb_data),
    .range_err   (range_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic vb, input logic cs);
    req         = r;
    vblank      = vb;
    clear_start = cs;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"}, 32'(fb_we), 32'd0);
    checkOutput({tag, "_x"}, 32'(fb_x), 32'd0);
    checkOutput({tag, "_y"}, 32'(fb_y), 32'd0);
    checkOutput({tag, "_data"}, 32'(fb_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(clear_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(clear_done), 32'd0);
    checkOutput({tag, "_rerr"}, 32'(range_err), 32'd0);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    int writes;
    int cyc;
    logic prevV;
    logic [COLOR_W-1:0] rrData [4];

    // Reset state
    #12;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;
    nextCycle();

    // Round-robin with both requesting: 01,10,01,10
    x0 = 4'd1; y0 = 5'd2; d0 = 3'b001;
    x1 = 4'd5; y1 = 5'd6; d1 = 3'b110;
    rrData[0] = 3'b001; rrData[1] = 3'b110; rrData[2] = 3'b001; rrData[3] = 3'b110;
    applyStimulus(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      nextCycle();
      checkOutput("rr_we", 32'(fb_we), 32'd1);
      checkOutput("rr_data", 32'(fb_data), 32'(rrData[i]));
      checkOutput("rr_x", 32'(fb_x), (i % 2 == 0) ? 32'd1 : 32'd5);
    end

    // Single request from req 0
    x0 = 4'd3; y0 = 5'd7; d0 = 3'b101;
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("single_gnt", 32'(gnt), 32'h1);
    nextCycle();
    checkOutput("single_we", 32'(fb_we), 32'd1);
    checkOutput("single_x", 32'(fb_x), 32'd3);
    checkOutput("single_y", 32'(fb_y), 32'd7);
    checkOutput("single_data", 32'(fb_data), 32'h5);

    // Held request while vblank is low for 5 cycles
    x0 = 4'd2; y0 = 5'd3; d0 = 3'b111;
    applyStimulus(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("novb_gnt", 32'(gnt), 32'd0);
      nextCycle();
      checkOutput("novb_we", 32'(fb_we), 32'd0);
    end
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("vbrise_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("vbfall_we", 32'(fb_we), 32'd1);
    checkOutput("vbfall_data", 32'(fb_data), 32'h7);
    checkOutput("vbfall_gnt", 32'(gnt), 32'd0);
    nextCycle();
    checkOutput("vbfall_we2", 32'(fb_we), 32'd0);

    // Out-of-range request is consumed without a write
    x1 = 4'd10; y1 = 5'd4; d1 = 3'b011;
    applyStimulus(2'b10, 1'b1, 1'b0);
    checkOutput("oor_gnt", 32'(gnt), 32'h2);
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("oor_we", 32'(fb_we), 32'd0);
    checkOutput("oor_rerr", 32'(range_err), 32'd1);
    nextCycle();
    checkOutput("oor_rerr_clr", 32'(range_err), 32'd0);

    // Clear with vblank 50 high / 50 low; req 0 held throughout
    x0 = 4'd4; y0 = 5'd4; d0 = 3'b010;
    applyStimulus(2'b01, 1'b1, 1'b1);
    checkOutput("clr_start_gnt", 32'(gnt), 32'd0);
    nextCycle();
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("clr_busy", 32'(clear_busy), 32'd1);
    checkOutput("clr_load_we", 32'(fb_we), 32'd0);
    writes = 0;
    cyc = 0;
    while (writes < 200 && cyc < 1000) begin
      vblank = ((cyc / 50) % 2 == 0);
      checkOutput("clr_gnt", 32'(gnt), 32'd0);
      prevV = vblank;
      nextCycle();
      cyc++;
      checkOutput("clr_we", 32'(fb_we), 32'(prevV));
      if (fb_we) begin
        checkOutput("clr_cell", 32'({fb_y, fb_x, fb_data}),
                    32'({5'(writes / 10), 4'(writes % 10), 3'b000}));
        checkOutput("clr_done", 32'(clear_done), (writes == 199) ? 32'd1 : 32'd0);
        writes++;
      end else begin
        checkOutput("clr_done_idle", 32'(clear_done), 32'd0);
      end
    end
    checkOutput("clr_count", 32'(writes), 32'd200);
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("clr_end_busy", 32'(clear_busy), 32'd0);
    checkOutput("post_clr_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("post_clr_we", 32'(fb_we), 32'd1);
    checkOutput("post_clr_x", 32'(fb_x), 32'd4);
    checkOutput("post_clr_data", 32'(fb_data), 32'h2);
    checkOutput("post_clr_done", 32'(clear_done), 32'd0);

    // Reset asserted asynchronously right after clear write 57
    applyStimulus(2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0);
    writes = 0;
    cyc = 0;
    while (writes < 57 && cyc < 200) begin
      nextCycle();
      cyc++;
      if (fb_we) writes++;
    end
    checkOutput("abort_count", 32'(writes), 32'd57);
    checkOutput("abort_pre_x", 32'(fb_x), 32'd6);
    checkOutput("abort_pre_y", 32'(fb_y), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("abort");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("abort_idle_gnt", 32'(gnt), 32'h1);
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("restart_busy", 32'(clear_busy), 32'd1);
    nextCycle();
    checkOutput("restart_we", 32'(fb_we), 32'd1);
    checkOutput("restart_x", 32'(fb_x), 32'd0);
    checkOutput("restart_y", 32'(fb_y), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
